pwm_fbase12k: RTL and testbench

- Fixed-frequency 8-bit PWM generator. Base frequency is about 12.2 kHz from a 50 MHz system clock.
- An 8-bit compare value sets the duty cycle. The compare value is sampled once per PWM period, so duty changes never produce glitches or runt pulses mid-period.
- Drives a single PWM output, e.g. a motor or LED driver, in the lab digital system.

---
 rtl/pwm_fbase12k.sv | 37 +++
 tb/tb_pwm_fbase12k.sv | 120 ++++++++++++
 2 files changed

// File: rtl/pwm_fbase12k.sv
// pwm_fbase12k: fixed-frequency PWM; the compare value is latched only at period boundaries
module pwm_fbase12k #(
    parameter int PRESCALE = 16,
    parameter int WIDTH    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] CompDat,
    output logic             PWM
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
    logic [PW-1:0] pre_q, pre_d;
    logic [WIDTH-1:0] cnt_q, cnt_d, duty_q, duty_d;
    logic pwm_q, pwm_d, tick;
    always_comb begin
        tick   = pre_q == PRE_MAX;
        pre_d  = tick ? '0 : pre_q + 1'b1;
        cnt_d  = tick ? cnt_q + 1'b1 : cnt_q;
        duty_d = (tick && &cnt_q) ? CompDat : duty_q;
        pwm_d  = cnt_q <= duty_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q  <= '0;
            cnt_q  <= '0;
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end
    assign PWM = pwm_q;
endmodule

// File: tb/tb_pwm_fbase12k.sv
// tb_pwm_fbase12k: scoreboard bench; expected high times are queued as duty values are driven
module tb_pwm_fbase12k;
    logic clk = 1'b0;
    logic rst;
    logic [7:0] comp_dat;
    logic pwm;
    int checks = 0;
    int errors = 0;
    int exp_high[$];
    int n = 0;
    int rise_t = 0;
    int t0 = -1;
    logic prev = 1'b0;

    pwm_fbase12k dut (.clk(clk), .rst(rst), .CompDat(comp_dat), .PWM(pwm));

    always #10 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    task automatic wait_level(input logic v);
        for (int i = 0; i < 9000 && pwm !== v; i++) cyc(1);
        check("wait_level", int'(pwm), int'(v));
    endtask

    task automatic next_fall();
        wait_level(1'b1);
        wait_level(1'b0);
    endtask

    task automatic next_rise();
        wait_level(1'b0);
        wait_level(1'b1);
    endtask

    // Monitor: measures high time on every fall and checks rise alignment to the 4096-clk period
    always @(negedge clk) begin
        n++;
        if (rst) begin
            prev = 1'b0;
            t0 = -1;
        end else begin
            if (pwm && !prev) begin
                rise_t = n;
                if (t0 < 0) t0 = n;
                else check("period", (n - t0) % 4096, 0);
            end
            if (!pwm && prev) begin
                if (exp_high.size() == 0) check("spurious_fall", 1, 0);
                else check("high_time", n - rise_t, exp_high.pop_front());
            end
            prev = pwm;
        end
    end

    initial begin
        rst = 1'b1;
        comp_dat = 8'd0;
        cyc(1);
        check("rst_pwm0", int'(pwm), 0);
        cyc(1);
        check("rst_pwm1", int'(pwm), 0);
        exp_high.push_back(16);
        rst = 1'b0;
        cyc(1);
        check("release_high", int'(pwm), 1);
        for (int v = 1; v <= 3; v++) begin
            next_fall();
            comp_dat = 8'(v);
            exp_high.push_back((v + 1) * 16);
        end
        next_fall();
        comp_dat = 8'd255;
        exp_high.push_back(4096 + 176);
        next_rise();
        cyc(100);
        comp_dat = 8'd10;
        next_fall();
        comp_dat = 8'd128;
        exp_high.push_back(2064);
        next_rise();
        cyc(800);
        comp_dat = 8'd20;
        exp_high.push_back(336);
        next_fall();
        next_fall();
        comp_dat = 8'd200;
        next_rise();
        cyc(1600);
        check("pre_rst_high", int'(pwm), 1);
        rst = 1'b1;
        cyc(1);
        check("mid_rst_low0", int'(pwm), 0);
        cyc(1);
        check("mid_rst_low1", int'(pwm), 0);
        comp_dat = 8'd50;
        exp_high.push_back(16);
        exp_high.push_back(816);
        rst = 1'b0;
        cyc(1);
        check("rerelease_high", int'(pwm), 1);
        next_fall();
        next_fall();
        cyc(10);
        check("queue_empty", exp_high.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
